// File: rtl/switch_debouncer_pkg.sv
// Shared defaults and sizing helpers for the switch debouncer.
// Imported by the debouncer top and its synchroniser.
package debounce_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int SW_W_DEF            = 8;

  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch-side signal bundle: raw levels in, debounced view out.
// master drives the raw levels, slave is the debouncer.
interface switch_debouncer_if #(
  parameter int SW_W = debounce_pkg::SW_W_DEF
);

  logic [SW_W-1:0] switch_raw;
  logic [SW_W-1:0] switch;
  logic            changed;
  logic            onehot;

  modport master (
    output switch_raw,
    input  switch,
    input  changed,
    input  onehot
  );

  modport slave (
    input  switch_raw,
    output switch,
    output changed,
    output onehot
  );

endinterface

// File: rtl/switch_debouncer_sync_2ff.sv
// Two-flop synchroniser for the asynchronous DIP switch levels.
// Each bit is synchronised independently; reset clears both stages.
module sync_2ff
  import debounce_pkg::*;
#(
  parameter int W = SW_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/switch_debouncer.sv
// Vector switch debouncer: one shared stability counter for all bits,
// commits the whole vector once it has been stable for the full window.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SW_W            = SW_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] switch_raw,
  output logic [SW_W-1:0] switch,
  output logic            changed,
  output logic            onehot
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0] s2;
  logic [SW_W-1:0] cand;
  logic [CW-1:0]   cnt;

  logic [SW_W-1:0] cand_d;
  logic [SW_W-1:0] sw_d;
  logic [CW-1:0]   cnt_d;
  logic            chg_d;
  logic            oh_d;

  logic diff;
  logic sat;
  logic fresh;

  sync_2ff #(
    .W (SW_W)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (switch_raw),
    .q     (s2)
  );

  assign diff  = (s2 != cand);
  assign sat   = (cnt >= CMAX);
  assign fresh = (cand != switch);

  always_comb begin
    cand_d = cand;
    cnt_d  = cnt;
    sw_d   = switch;
    chg_d  = 1'b0;
    oh_d   = onehot;
    unique case (1'b1)
      diff: begin
        cand_d = s2;
        cnt_d  = '0;
      end
      (!diff && !sat): begin
        cnt_d = cnt + CW'(1);
      end
      (!diff && sat && fresh): begin
        sw_d  = cand;
        chg_d = 1'b1;
        oh_d  = ($countones(cand) == 1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand    <= '0;
      cnt     <= '0;
      switch  <= '0;
      changed <= 1'b0;
      onehot  <= 1'b0;
    end else begin
      cand    <= cand_d;
      cnt     <= cnt_d;
      switch  <= sw_d;
      changed <= chg_d;
      onehot  <= oh_d;
    end
  end

endmodule
